// File: rtl/sync_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_frame_pkg
//  Description : Shared constants for the sync-frame receiver and its SPI
//                readout port (default frame geometry, status width, SPI
//                state encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_frame_pkg;

    localparam int          c_FRAME_LEN_DEF = 64;
    localparam logic [63:0] c_SYNC_MASK_DEF = 64'h7C00_001F_0000_01FF;
    localparam logic [63:0] c_SYNC_VAL_DEF  = 64'h7C00_001F_0000_01FF;

    // Width of the optional status byte prepended to the SPI readout
    localparam int          c_STATUS_W      = 8;

    // SPI slave state encoding
    localparam logic [1:0]  c_ST_IDLE       = 2'd0;
    localparam logic [1:0]  c_ST_XFER       = 2'd1;
    localparam logic [1:0]  c_ST_DONE       = 2'd2;

endpackage : sync_frame_pkg
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_if
//  Description : Mode-0 SPI slave. Synchronises CS/SCK/MOSI into clk, shifts
//                a snapshot of the held frame out MSB-first on MISO, collects
//                MOSI bytes, and flags a complete read so the frame can be
//                released by the owner of the holding buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_if
    import sync_frame_pkg::*;
#(
    parameter int TX_W        = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            CS,
    input  logic            SCK,
    input  logic            MOSI,
    input  logic [TX_W-1:0] tx_load,
    output logic            MISO,
    output logic [7:0]      rx_byte,
    output logic            rx_valid,
    output logic            consume
);

    localparam int                 c_BIT_W   = $clog2(TX_W + 1);
    localparam logic [c_BIT_W-1:0] c_BIT_END = c_BIT_W'(TX_W);

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic                   r_sck_d;
    logic                   r_armed;
    logic [1:0]             r_state;
    logic [TX_W-1:0]        r_tx;
    logic [c_BIT_W-1:0]     r_bit_cnt;
    logic [2:0]             r_rx_cnt;
    logic [6:0]             r_rx_sh;
    logic [7:0]             r_rx_byte;
    logic                   r_rx_valid;

    logic w_cs_s;
    logic w_sck_s;
    logic w_mosi_s;
    logic w_sck_rise;
    logic w_sck_fall;

    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;

    // Synchronisers; r_sync_vld marks when the CS chain holds real pin samples
    // rather than its reset value, so a transaction already running at reset
    // release is not mistaken for a fresh CS fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync   <= '1;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_sync_vld  <= '0;
            r_sck_d     <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            r_sck_d     <= w_sck_s;
        end
    end

    // SPI transfer state machine with tx/rx shifters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_armed    <= 1'b0;
            r_tx       <= '0;
            r_bit_cnt  <= '0;
            r_rx_cnt   <= '0;
            r_rx_sh    <= '0;
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // A CS fall only starts a transfer once CS was seen high
                    if (r_armed && !w_cs_s) begin
                        r_tx      <= tx_load;
                        r_bit_cnt <= '0;
                        r_rx_cnt  <= '0;
                        r_rx_sh   <= '0;
                        r_armed   <= 1'b0;
                        r_state   <= c_ST_XFER;
                    end else if (w_cs_s && r_sync_vld[SYNC_STAGES-1]) begin
                        r_armed <= 1'b1;
                    end
                end
                c_ST_XFER: begin
                    if (w_cs_s) begin
                        // Partial MOSI byte is simply abandoned
                        r_tx    <= '0;
                        r_state <= c_ST_DONE;
                    end else if (w_sck_rise) begin
                        r_rx_sh  <= {r_rx_sh[5:0], w_mosi_s};
                        r_rx_cnt <= r_rx_cnt + 3'd1;
                        if (r_bit_cnt != c_BIT_END) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                        if (r_rx_cnt == 3'd7) begin
                            r_rx_byte  <= {r_rx_sh, w_mosi_s};
                            r_rx_valid <= 1'b1;
                        end
                    end else if (w_sck_fall) begin
                        // Zero fill makes MISO read 0 once every bit is out
                        r_tx <= {r_tx[TX_W-2:0], 1'b0};
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign consume  = (r_state == c_ST_DONE) && (r_bit_cnt == c_BIT_END);
    assign MISO     = r_tx[TX_W-1] & ~CS;
    assign rx_byte  = r_rx_byte;
    assign rx_valid = r_rx_valid;

endmodule : spi_slave_if
`default_nettype wire

// File: rtl/sync_frame_spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : sync_frame_spi_rx
//  Description : Serial frame receiver. Shifts din on sh_en, detects a frame
//                by masked sync-bit compare, holds it in a one-deep buffer and
//                exposes it to an external SPI master through spi_slave_if.
//                Build option SPI_STATUS_BYTE_EN prepends the status byte
//                {frame_valid, overrun, 6'd0} ahead of the frame on MISO.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_frame_spi_rx
    import sync_frame_pkg::*;
#(
    parameter int                   FRAME_LEN   = c_FRAME_LEN_DEF,
    parameter logic [FRAME_LEN-1:0] SYNC_MASK   = c_SYNC_MASK_DEF,
    parameter logic [FRAME_LEN-1:0] SYNC_VAL    = c_SYNC_VAL_DEF,
    parameter int                   SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       sh_en,
    input  logic       CS,
    input  logic       SCK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       pkt_rec,
    output logic       frame_valid,
    output logic       overrun,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);

    localparam int                 c_CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_FILL_FULL = c_CNT_W'(FRAME_LEN);
`ifdef SPI_STATUS_BYTE_EN
    localparam int                 c_TX_W      = FRAME_LEN + c_STATUS_W;
`else
    localparam int                 c_TX_W      = FRAME_LEN;
`endif

    logic [FRAME_LEN-1:0] r_shreg;
    logic [FRAME_LEN-1:0] r_buffer;
    logic [c_CNT_W-1:0]   r_fill_cnt;
    logic                 r_frame_valid;
    logic                 r_overrun;

    logic                 w_detect;
    logic                 w_consume;
    logic [c_TX_W-1:0]    w_tx_load;

    // Match is judged on the already-shifted register, so it fires the cycle
    // after the completing sh_en
    assign w_detect = (r_fill_cnt == c_FILL_FULL) &&
                      ((r_shreg & SYNC_MASK) == (SYNC_VAL & SYNC_MASK));

    // Shift register and fill counter; a detect restarts the fill count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg    <= '0;
            r_fill_cnt <= '0;
        end else begin
            if (sh_en) begin
                r_shreg <= {r_shreg[FRAME_LEN-2:0], din};
            end
            if (w_detect) begin
                r_fill_cnt <= sh_en ? c_CNT_W'(1) : '0;
            end else if (sh_en && (r_fill_cnt != c_FILL_FULL)) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end
        end
    end

    // Holding buffer; a consume in the same cycle frees the slot for the new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buffer      <= '0;
            r_frame_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_detect && (!r_frame_valid || w_consume)) begin
                r_buffer      <= r_shreg;
                r_frame_valid <= 1'b1;
            end else if (w_consume) begin
                r_frame_valid <= 1'b0;
            end
            if (w_consume) begin
                r_overrun <= 1'b0;
            end else if (w_detect && r_frame_valid) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef SPI_STATUS_BYTE_EN
    assign w_tx_load = {r_frame_valid, r_overrun, 6'd0, r_buffer};
`else
    assign w_tx_load = r_buffer;
`endif

    spi_slave_if #(
        .TX_W        (c_TX_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_spi (
        .clk      (clk),
        .rst_n    (rst_n),
        .CS       (CS),
        .SCK      (SCK),
        .MOSI     (MOSI),
        .tx_load  (w_tx_load),
        .MISO     (MISO),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .consume  (w_consume)
    );

    assign pkt_rec     = w_detect;
    assign frame_valid = r_frame_valid;
    assign overrun     = r_overrun;

endmodule : sync_frame_spi_rx
`default_nettype wire

// File: tb/tb_sync_frame_spi_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_frame_spi_rx
//  Description : Self-checking bench for sync_frame_spi_rx. Expected frames
//                and MOSI bytes are queued when stimulus is driven and popped
//                when the DUT reads them out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_frame_spi_rx;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       din   = 1'b0;
    logic       sh_en = 1'b0;
    logic       CS    = 1'b1;
    logic       SCK   = 1'b0;
    logic       MOSI  = 1'b0;
    logic       MISO;
    logic       pkt_rec;
    logic       frame_valid;
    logic       overrun;
    logic [7:0] rx_byte;
    logic       rx_valid;

    int n_checks = 0;
    int n_errors = 0;
    int pkt_cnt  = 0;

    logic [63:0] exp_frame_q[$];
    logic [7:0]  exp_rx_q[$];
    bit          m_fv = 1'b0;
    bit          m_ov = 1'b0;

    logic [63:0] sync_mask = 64'h7C00_001F_0000_01FF;
    // Zeros here break every 9-bit run of ones, so no shifted window of a
    // frame can satisfy the sync compare before the whole frame is in
    logic [63:0] guard_zero = (64'd1 << 9)  | (64'd1 << 17) | (64'd1 << 25) |
                              (64'd1 << 31) | (64'd1 << 37) | (64'd1 << 45) |
                              (64'd1 << 53) | (64'd1 << 57);

    always #5 clk = ~clk;

    sync_frame_spi_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .sh_en       (sh_en),
        .CS          (CS),
        .SCK         (SCK),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .pkt_rec     (pkt_rec),
        .frame_valid (frame_valid),
        .overrun     (overrun),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Count detect pulses and score every received MOSI byte
    always @(negedge clk) begin
        if (pkt_rec === 1'b1) pkt_cnt++;
        if (rx_valid === 1'b1) begin
            if (exp_rx_q.size() == 0) check("rx_unexpected_valid", 64'd1, 64'd0);
            else                      check("rx_byte", {56'd0, rx_byte}, {56'd0, exp_rx_q.pop_front()});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, required end of test");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] make_frame();
        logic [63:0] f;
        f = {$urandom(), $urandom()};
        f = (f & ~sync_mask & ~guard_zero) | sync_mask;
        return f;
    endfunction

    // 8 zero bits, then the frame MSB first; updates the buffer model
    task automatic send_frame(input logic [63:0] f, input bit good);
        int   pulses = 0;
        logic at_end = 1'b0;
        for (int i = 0; i < 72; i++) begin
            @(posedge clk); #2;
            din   = (i < 8) ? 1'b0 : f[71 - i];
            sh_en = 1'b1;
            @(posedge clk); #2;
            sh_en = 1'b0;
            @(negedge clk);
            if (pkt_rec) pulses++;
            at_end = pkt_rec;
        end
        check("pkt_after_last_shift", {63'd0, at_end}, {63'd0, good});
        @(negedge clk);
        if (pkt_rec) pulses++;
        check("pkt_pulse_count", pulses, good);
        if (good) begin
            if (!m_fv) begin
                exp_frame_q.push_back(f);
                m_fv = 1'b1;
            end else begin
                m_ov = 1'b1;
            end
        end
        check("frame_valid", {63'd0, frame_valid}, {63'd0, m_fv});
        check("overrun", {63'd0, overrun}, {63'd0, m_ov});
        din = 1'b0;
    endtask

    // SPI mode-0 master read of nbits; MOSI bytes are first_byte, +step, ...
    task automatic spi_read(input int nbits, input logic [7:0] first_byte, input logic [7:0] step);
        logic [63:0] got = '0;
        logic [63:0] exp;
        logic [7:0]  b;
        exp = (exp_frame_q.size() > 0) ? exp_frame_q[0] : 64'd0;
        b   = first_byte;
        for (int k = 0; k < nbits / 8; k++) begin
            exp_rx_q.push_back(b);
            b = b + step;
        end
        b  = first_byte;
        CS = 1'b0;
        tick(8);
        for (int i = 0; i < nbits; i++) begin
            MOSI = b[7 - (i % 8)];
            tick(8);
            got = {got[62:0], MISO};
            SCK = 1'b1;
            tick(8);
            SCK = 1'b0;
            if ((i % 8) == 7) b = b + step;
        end
        tick(8);
        CS = 1'b1;
        check("miso_stream", got, exp >> (64 - nbits));
        tick(2);
        check("miso_cs_high", {63'd0, MISO}, 64'd0);
        tick(8);
        if (nbits >= 64) begin
            if (exp_frame_q.size() > 0) void'(exp_frame_q.pop_front());
            m_fv = 1'b0;
            m_ov = 1'b0;
        end
        check("frame_valid_after_read", {63'd0, frame_valid}, {63'd0, m_fv});
        check("overrun_after_read", {63'd0, overrun}, {63'd0, m_ov});
    endtask

    initial begin
        logic [63:0] f;

        // Reset state
        tick(3);
        check("reset_outputs", {51'd0, MISO, pkt_rec, frame_valid, overrun, rx_valid, rx_byte}, 64'd0);
        rst_n = 1'b1;
        tick(4);

        // Frame with one sync bit wrong must not be detected
        f = make_frame();
        f[60] = 1'b0;
        send_frame(f, 1'b0);

        // Good frame, then full read with MOSI 0xC3 repeated
        send_frame(make_frame(), 1'b1);
        spi_read(64, 8'hC3, 8'h00);

        // Two frames back to back: second is dropped and flags overrun
        send_frame(make_frame(), 1'b1);
        send_frame(make_frame(), 1'b1);
        spi_read(64, 8'h10, 8'h01);

        // Aborted read keeps the frame; the next full read returns it intact
        send_frame(make_frame(), 1'b1);
        spi_read(20, 8'hA5, 8'h11);
        spi_read(64, 8'h3C, 8'h01);

        // Reset asserted mid-transfer with CS held low
        send_frame(make_frame(), 1'b1);
        CS = 1'b0;
        tick(8);
        for (int i = 0; i < 6; i++) begin
            MOSI = 1'b1;
            tick(8);
            SCK = 1'b1;
            tick(8);
            SCK = 1'b0;
        end
        tick(4);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        exp_frame_q.delete();
        m_fv = 1'b0;
        m_ov = 1'b0;
        tick(1);
        check("reset_mid_xfer_outputs", {51'd0, MISO, pkt_rec, frame_valid, overrun, rx_valid, rx_byte}, 64'd0);
        for (int i = 0; i < 16; i++) begin
            MOSI = i[0];
            tick(8);
            SCK = 1'b1;
            tick(8);
            SCK = 1'b0;
        end
        tick(8);
        check("miso_after_reset", {63'd0, MISO}, 64'd0);
        check("frame_valid_after_reset", {63'd0, frame_valid}, 64'd0);
        CS = 1'b1;
        tick(8);
        spi_read(64, 8'h5A, 8'h01);

        tick(10);
        check("rx_queue_drained", exp_rx_q.size(), 64'd0);
        check("pkt_rec_total", pkt_cnt, 64'd5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sync_frame_spi_rx
`default_nettype wire
